// File: rtl/dctq_pkg.sv
// Shared widths, constants and types for the DCTQ quantizer path.
// Consumers: dct_quantizer_if, dct_quantizer, dctq_round_sat.
package dctq_pkg;
   localparam int SUM_W    = 17;
   localparam int OUT_W    = 12;
   localparam int RCP_W    = 16;
   localparam int RCP_FRAC = 15;
   localparam int PROD_W   = SUM_W + RCP_W + 1;
   localparam int IDX_W    = 6;
   localparam int NZ_W     = 7;
   localparam int BLK_SIZE = 64;
   localparam int RCP_ONE  = 32768;

   typedef logic [IDX_W-1:0] coef_idx_t;
   typedef logic [RCP_W-1:0] rcp_t;
endpackage

// File: rtl/dct_quantizer_if.sv
// Bus bundle for dct_quantizer: source beat, quant-table write port, quantized stream.
// Optional macro DCTQ_NZ_COUNT_EN adds the nz_count output.
interface dct_quantizer_if;
   import dctq_pkg::*;

   // Handshake: src_valid, qt_we and q_valid are single-cycle strobes with no ready.
   // Every strobed beat is taken in the cycle it is high; neither side can stall.
   logic                    src_valid;
   logic signed [SUM_W-1:0] sum_in;
   logic                    qt_we;
   coef_idx_t               qt_addr;
   rcp_t                    qt_data;
   logic signed [OUT_W-1:0] q_out;
   logic                    q_valid;
   coef_idx_t               q_index;
   logic                    blk_last;
`ifdef DCTQ_NZ_COUNT_EN
   logic [NZ_W-1:0]         nz_count;

   modport master (output src_valid, sum_in, qt_we, qt_addr, qt_data,
                   input  q_out, q_valid, q_index, blk_last, nz_count);
   modport slave  (input  src_valid, sum_in, qt_we, qt_addr, qt_data,
                   output q_out, q_valid, q_index, blk_last, nz_count);
`else
   modport master (output src_valid, sum_in, qt_we, qt_addr, qt_data,
                   input  q_out, q_valid, q_index, blk_last);
   modport slave  (input  src_valid, sum_in, qt_we, qt_addr, qt_data,
                   output q_out, q_valid, q_index, blk_last);
`endif
endinterface

// File: rtl/dctq_round_sat.sv
// Combinational round-half-away-from-zero of a fixed-point product, then saturate
// to a signed OUT_W result. Shared by the forward and inverse quantizer paths.
module dctq_round_sat #(
   parameter int IN_W  = 34,
   parameter int OUT_W = 12,
   parameter int FRAC  = 15
) (
   input  logic signed [IN_W-1:0]  p,
   output logic signed [OUT_W-1:0] q
);
   localparam logic [IN_W-1:0] HALF    = IN_W'(64'd1 << (FRAC - 1));
   localparam logic [IN_W-1:0] POS_MAX = IN_W'((64'd1 << (OUT_W - 1)) - 64'd1);
   localparam logic [IN_W-1:0] NEG_MAX = IN_W'(64'd1 << (OUT_W - 1));

   logic              neg;
   logic [IN_W-1:0]   mag;
   logic [IN_W-1:0]   r_mag;
   logic [OUT_W-1:0]  r_lo;

   // Rounding on the magnitude gives symmetric behaviour around zero.
   always_comb begin
      neg   = p[IN_W-1];
      mag   = neg ? $unsigned(-p) : $unsigned(p);
      r_mag = (mag + HALF) >> FRAC;
      r_lo  = r_mag[OUT_W-1:0];
      if (!neg) begin
         q = (r_mag > POS_MAX) ? $signed(POS_MAX[OUT_W-1:0]) : $signed(r_lo);
      end else if (r_mag > NEG_MAX) begin
         q = $signed(NEG_MAX[OUT_W-1:0]);
      end else begin
         q = $signed(-r_lo);
      end
   end
endmodule

// File: rtl/dct_quantizer.sv
// Quantizer behind the 8-input adder tree: aligns valid, tracks the 8x8 index,
// scales by a loadable reciprocal table, rounds and saturates. Macro: DCTQ_NZ_COUNT_EN.
module dct_quantizer
   import dctq_pkg::*;
#(
   parameter int ADDER_LAT = 5
) (
   input logic             clk,
   input logic             rst,
   dct_quantizer_if.slave  bus
);
   logic [ADDER_LAT-1:0]     vsr;
   logic                     v0;
   coef_idx_t                idx;
   rcp_t                     qt [BLK_SIZE];

   logic                     s1_v;
   logic signed [SUM_W-1:0]  s1_sum;
   coef_idx_t                s1_idx;
   rcp_t                     s1_rcp;

   logic                     s2_v;
   logic signed [PROD_W-1:0] s2_p;
   coef_idx_t                s2_idx;

   logic signed [OUT_W-1:0]  rs_q;

   assign v0 = vsr[ADDER_LAT-1];

   // Writes land on the edge, so a same-cycle S1 read still sees the old entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BLK_SIZE; i++) qt[i] <= rcp_t'(RCP_ONE);
      end else if (bus.qt_we) begin
         qt[bus.qt_addr] <= bus.qt_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vsr          <= '0;
         idx          <= '0;
         s1_v         <= 1'b0;
         s2_v         <= 1'b0;
         bus.q_valid  <= 1'b0;
         bus.q_out    <= '0;
         bus.q_index  <= '0;
         bus.blk_last <= 1'b0;
      end else begin
         vsr <= {vsr[ADDER_LAT-2:0], bus.src_valid};
         if (v0) idx <= idx + coef_idx_t'(1);

         s1_v <= v0;
         if (v0) begin
            s1_sum <= bus.sum_in;
            s1_idx <= idx;
            s1_rcp <= qt[idx];
         end

         s2_v <= s1_v;
         if (s1_v) begin
            s2_p   <= PROD_W'(s1_sum) * PROD_W'($signed({1'b0, s1_rcp}));
            s2_idx <= s1_idx;
         end

         bus.q_valid  <= s2_v;
         bus.blk_last <= s2_v && (s2_idx == coef_idx_t'(BLK_SIZE - 1));
         if (s2_v) begin
            bus.q_out   <= rs_q;
            bus.q_index <= s2_idx;
         end
      end
   end

   dctq_round_sat #(
      .IN_W  (PROD_W),
      .OUT_W (OUT_W),
      .FRAC  (RCP_FRAC)
   ) u_round_sat (
      .p (s2_p),
      .q (rs_q)
   );

`ifdef DCTQ_NZ_COUNT_EN
   logic nz_done;

   // Count lags q_out by one cycle so the final total is visible after blk_last.
   always_ff @(posedge clk) begin
      if (rst) begin
         nz_done      <= 1'b0;
         bus.nz_count <= '0;
      end else begin
         nz_done      <= bus.q_valid && bus.blk_last;
         bus.nz_count <= (nz_done ? NZ_W'(0) : bus.nz_count)
                         + NZ_W'(bus.q_valid && (bus.q_out != '0));
      end
   end
`endif
endmodule

// File: tb/tb_dct_quantizer.sv
// Self-checking bench for dct_quantizer: arithmetic reference model, expected queue,
// scenario tasks run in sequence, one summary line.
module tb_dct_quantizer;
   import dctq_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dct_quantizer_if bus ();

   dct_quantizer #(.ADDER_LAT(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp   = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_valid = 0;

   // Entry layout: {q[11:0], index[5:0], last}
   logic [18:0]       exp_q[$];
   logic [18:0]       obs_q[$];
   int                obs_cyc_q[$];
   int                nz_q[$];
   longint            tbl [64];
   logic signed [16:0] sum_at [int];
   logic              prev_last = 1'b0;

   function automatic logic [11:0] ref_quant(input longint s, input longint rcp);
      longint p;
      longint r;
      p = s * rcp;
      if (p >= 0) r = (p + 16384) / 32768;
      else        r = -((-p + 16384) / 32768);
      if (r > 2047)  r = 2047;
      if (r < -2048) r = -2048;
      return 12'(r);
   endfunction

   // Driver: applies one cycle of inputs, models the adder-tree timing and
   // table semantics, then samples outputs 1 ns after the edge.
   task automatic step(input logic v, input logic signed [16:0] s, input logic we,
                       input logic [5:0] a, input logic [15:0] d, input logic r);
      int k;
      rst           = r;
      bus.src_valid = v;
      bus.qt_we     = we;
      bus.qt_addr   = a;
      bus.qt_data   = d;
      bus.sum_in    = sum_at.exists(cyc) ? sum_at[cyc] : 17'($urandom);
      if (r) begin
         sum_at.delete();
         exp_q.delete();
         n_valid = 0;
         foreach (tbl[i]) tbl[i] = 32768;
      end else begin
         if (sum_at.exists(cyc)) begin
            k = n_valid % 64;
            exp_q.push_back({ref_quant(longint'(sum_at[cyc]), tbl[k]), 6'(k), (k == 63)});
            n_valid++;
            sum_at.delete(cyc);
         end
         if (v) sum_at[cyc + 5] = s;
         if (we) tbl[a] = longint'(d);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (bus.q_valid === 1'b1) begin
         obs_q.push_back({bus.q_out, bus.q_index, bus.blk_last});
         obs_cyc_q.push_back(cyc);
      end
`ifdef DCTQ_NZ_COUNT_EN
      if (prev_last) nz_q.push_back(int'(bus.nz_count));
`endif
      prev_last = (bus.q_valid === 1'b1) && (bus.blk_last === 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 17'sd0, 1'b0, 6'd0, 16'd0, 1'b0);
   endtask

   task automatic send(input logic signed [16:0] s);
      step(1'b1, s, 1'b0, 6'd0, 16'd0, 1'b0);
   endtask

   task automatic wr(input logic [5:0] a, input logic [15:0] d);
      step(1'b0, 17'sd0, 1'b1, a, d, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 17'sd0, 1'b0, 6'd0, 16'd0, 1'b1);
      step(1'b0, 17'sd0, 1'b0, 6'd0, 16'd0, 1'b1);
      step(1'b0, 17'sd0, 1'b0, 6'd0, 16'd0, 1'b0);
      obs_q.delete();
      obs_cyc_q.delete();
      nz_q.delete();
      prev_last = 1'b0;
   endtask

   task automatic test_reset();
      // rst and qt_we together: rst must win, so entry 0 stays pass-through
      step(1'b0, 17'sd0, 1'b1, 6'd0, 16'd1, 1'b1);
      step(1'b0, 17'sd0, 1'b1, 6'd0, 16'd1, 1'b1);
      n_cmp++;
      if (bus.q_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_q_valid: got %b want 0", bus.q_valid);
      end
      n_cmp++;
      if (bus.q_out !== 12'd0) begin
         n_fail++; $display("FAIL reset_q_out: got %0d want 0", bus.q_out);
      end
      n_cmp++;
      if (bus.q_index !== 6'd0) begin
         n_fail++; $display("FAIL reset_q_index: got %0d want 0", bus.q_index);
      end
      n_cmp++;
      if (bus.blk_last !== 1'b0) begin
         n_fail++; $display("FAIL reset_blk_last: got %b want 0", bus.blk_last);
      end
`ifdef DCTQ_NZ_COUNT_EN
      n_cmp++;
      if (bus.nz_count !== 7'd0) begin
         n_fail++; $display("FAIL reset_nz_count: got %0d want 0", bus.nz_count);
      end
`endif
      step(1'b0, 17'sd0, 1'b0, 6'd0, 16'd0, 1'b0);
      obs_q.delete();
      obs_cyc_q.delete();
   endtask

   task automatic test_pass_through();
      int t0;
      logic [18:0] o;
      t0 = cyc;
      send(17'sd1000);
      idle(12);
      n_cmp++;
      if (obs_q.size() != 1 || exp_q.size() != 1) begin
         n_fail++;
         $display("FAIL pass_count: got %0d outputs (%0d expected queued) want 1", obs_q.size(), exp_q.size());
      end else begin
         o = obs_q.pop_front();
         n_cmp++;
         if (o !== exp_q.pop_front()) begin
            n_fail++; $display("FAIL pass_model: got q=%0d idx=%0d", $signed(o[18:7]), o[6:1]);
         end
         n_cmp++;
         if ($signed(o[18:7]) !== 12'sd1000 || o[6:1] !== 6'd0) begin
            n_fail++; $display("FAIL pass_value: got q=%0d idx=%0d want q=1000 idx=0", $signed(o[18:7]), o[6:1]);
         end
         n_cmp++;
         if (obs_cyc_q[0] != t0 + 8) begin
            n_fail++; $display("FAIL pass_latency: got %0d cycles want 8", obs_cyc_q[0] - t0);
         end
      end
      obs_cyc_q.delete();
   endtask

   task automatic test_saturation();
      int sat_in [3]  = '{5000, -5000, -65536};
      int sat_exp [3] = '{2047, -2048, -2048};
      logic [18:0] o;
      do_reset();
      for (int i = 0; i < 3; i++) send(17'(sat_in[i]));
      idle(12);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (obs_q.size() == 0 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL sat_missing_%0d: got no output want q=%0d", i, sat_exp[i]);
         end else begin
            o = obs_q.pop_front();
            if (o[18:7] !== 12'(sat_exp[i]) || o !== exp_q.pop_front()) begin
               n_fail++;
               $display("FAIL sat_%0d: got q=%0d idx=%0d want q=%0d idx=%0d", i, $signed(o[18:7]), o[6:1], sat_exp[i], i);
            end
         end
      end
   endtask

   task automatic test_quant_q16();
      int q_in [4]  = '{24, -24, 23, -8};
      int q_exp [4] = '{2, -2, 1, -1};
      logic [18:0] o;
      do_reset();
      for (int i = 0; i < 64; i++) wr(6'(i), 16'd2048);
      for (int i = 0; i < 4; i++) send(17'(q_in[i]));
      idle(12);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (obs_q.size() == 0 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL q16_missing_%0d: got no output want q=%0d", i, q_exp[i]);
         end else begin
            o = obs_q.pop_front();
            if (o[18:7] !== 12'(q_exp[i]) || o !== exp_q.pop_front()) begin
               n_fail++; $display("FAIL q16_%0d: got q=%0d want q=%0d", i, $signed(o[18:7]), q_exp[i]);
            end
         end
      end
   endtask

   task automatic test_block_wrap();
      logic [18:0] got[$];
      logic [18:0] o;
      logic [18:0] e;
      int nz_exp = 0;
      int lasts  = 0;
      do_reset();
      for (int i = 0; i < 65; i++) send(17'($urandom_range(0, 131071)));
      idle(12);
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         got.push_back(o);
         if (got.size() <= 64 && e[18:7] != 12'd0) nz_exp++;
         if (o[0] === 1'b1) lasts++;
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL wrap_model: got q=%0d idx=%0d last=%0b want q=%0d idx=%0d last=%0b",
                     $signed(o[18:7]), o[6:1], o[0], $signed(e[18:7]), e[6:1], e[0]);
         end
      end
      n_cmp++;
      if (got.size() != 65 || lasts != 1) begin
         n_fail++; $display("FAIL wrap_count: got %0d outputs %0d lasts want 65 and 1", got.size(), lasts);
      end else begin
         n_cmp++;
         if (got[63][6:0] !== {6'd63, 1'b1} || got[64][6:0] !== {6'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_edge: got idx63/last=%0d/%0b idx64/last=%0d/%0b want 63/1 0/0",
                     got[63][6:1], got[63][0], got[64][6:1], got[64][0]);
         end
      end
`ifdef DCTQ_NZ_COUNT_EN
      n_cmp++;
      if (nz_q.size() != 1 || nz_q[0] != nz_exp) begin
         n_fail++; $display("FAIL wrap_nz_count: got %0d samples first=%0d want %0d", nz_q.size(),
                            (nz_q.size() > 0) ? nz_q[0] : -1, nz_exp);
      end
`endif
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_table_hazard();
      logic [18:0] got[$];
      logic [18:0] o;
      logic [18:0] e;
      logic signed [16:0] s;
      do_reset();
      for (int i = 0; i < 70; i++) begin
         s = (i == 5 || i == 69) ? 17'sd100 : 17'($urandom_range(0, 131071));
         // iteration 10 is the cycle in which index 5's sum reaches S1
         if (i == 10) step(1'b1, s, 1'b1, 6'd5, 16'd4096, 1'b0);
         else         send(s);
      end
      idle(12);
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         got.push_back(o);
         n_cmp++;
         if (o !== e) begin
            n_fail++; $display("FAIL hazard_model: got q=%0d idx=%0d want q=%0d idx=%0d",
                               $signed(o[18:7]), o[6:1], $signed(e[18:7]), e[6:1]);
         end
      end
      n_cmp++;
      if (got.size() != 70) begin
         n_fail++; $display("FAIL hazard_count: got %0d outputs want 70", got.size());
      end else begin
         n_cmp++;
         if ($signed(got[5][18:7]) !== 12'sd100 || $signed(got[69][18:7]) !== 12'sd13) begin
            n_fail++; $display("FAIL hazard_values: got %0d then %0d want 100 then 13",
                               $signed(got[5][18:7]), $signed(got[69][18:7]));
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_random();
      logic [18:0] o;
      logic [18:0] e;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) < 7), 17'($urandom_range(0, 131071)),
              ($urandom_range(0, 9) == 0), 6'($urandom_range(0, 63)),
              16'($urandom_range(0, 65535)), 1'b0);
      end
      idle(12);
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL random_model: got q=%0d idx=%0d last=%0b want q=%0d idx=%0d last=%0b",
                     $signed(o[18:7]), o[6:1], o[0], $signed(e[18:7]), e[6:1], e[0]);
         end
      end
      n_cmp++;
      if (obs_q.size() != 0 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL random_leftover: got %0d extra outputs %0d missing want 0 and 0",
                            obs_q.size(), exp_q.size());
      end
   endtask

   task automatic test_mid_block_reset();
      logic [18:0] o;
      logic [18:0] e;
      do_reset();
      for (int i = 0; i < 30; i++) send(17'($urandom_range(1, 4000)));
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_fail++; $display("FAIL midrst_pre: got q=%0d idx=%0d want q=%0d idx=%0d",
                               $signed(o[18:7]), o[6:1], $signed(e[18:7]), e[6:1]);
         end
      end
      step(1'b0, 17'sd0, 1'b0, 6'd0, 16'd0, 1'b1);
      obs_q.delete();
      idle(12);
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_fail++; $display("FAIL midrst_flush: got %0d outputs after reset want 0", obs_q.size());
      end
`ifdef DCTQ_NZ_COUNT_EN
      n_cmp++;
      if (bus.nz_count !== 7'd0) begin
         n_fail++; $display("FAIL midrst_nz_count: got %0d want 0", bus.nz_count);
      end
`endif
      obs_q.delete();
      send(17'sd777);
      idle(12);
      n_cmp++;
      if (obs_q.size() != 1) begin
         n_fail++; $display("FAIL midrst_next_count: got %0d outputs want 1", obs_q.size());
      end else begin
         o = obs_q.pop_front();
         if (o !== {12'd777, 6'd0, 1'b0}) begin
            n_fail++; $display("FAIL midrst_next: got q=%0d idx=%0d want q=777 idx=0", $signed(o[18:7]), o[6:1]);
         end
      end
      exp_q.delete();
   endtask

   initial begin
      rst           = 1'b1;
      bus.src_valid = 1'b0;
      bus.sum_in    = '0;
      bus.qt_we     = 1'b0;
      bus.qt_addr   = '0;
      bus.qt_data   = '0;
      foreach (tbl[i]) tbl[i] = 32768;
      test_reset();
      test_pass_through();
      test_saturation();
      test_quant_q16();
      test_block_wrap();
      test_table_hazard();
      test_random();
      test_mid_block_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
